// File: rtl/idp_pkg.sv
// Shared types and constants for the idp sequencer: FSM states, instruction classes,
// branch conditions and instruction field positions.
package idp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_FETCH_IMM,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_BRANCH  = 2'b10;
  localparam logic [1:0] CLS_HALT    = 2'b11;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_N      = 2'b10;
  localparam logic [1:0] COND_C      = 2'b11;

  localparam int CLS_MSB  = 15;
  localparam int CLS_LSB  = 14;
  localparam int OP_MSB   = 13;
  localparam int OP_LSB   = 10;
  localparam int RD_MSB   = 9;
  localparam int RD_LSB   = 7;
  localparam int RS1_MSB  = 6;
  localparam int RS1_LSB  = 4;
  localparam int RS2_MSB  = 3;
  localparam int RS2_LSB  = 1;
  localparam int COND_MSB = 13;
  localparam int COND_LSB = 12;
  localparam int OFF_MSB  = 11;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] aluop;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [1:0] cond;
  } dec_t;

  function automatic logic cond_met(input logic [1:0] cond, input logic nf,
                                    input logic zf, input logic cf);
    case (cond)
      COND_Z:  return zf;
      COND_N:  return nf;
      COND_C:  return cf;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/idp_ctrl_if.sv
// Instruction-memory fetch port plus the idp datapath control/flag bundle.
interface idp_ctrl_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [15:0]     imem_data;
  logic            imem_valid;
  logic            N;
  logic            Z;
  logic            C;
  logic            en;
  logic            sel;
  logic [2:0]      write_add;
  logic [2:0]      fir_add;
  logic [2:0]      sec_add;
  logic [3:0]      opcode;
  logic [15:0]     secin;

  modport master (
    output imem_addr, imem_rd, en, sel, write_add, fir_add, sec_add, opcode, secin,
    input  imem_data, imem_valid, N, Z, C
  );

  modport slave (
    input  imem_addr, imem_rd, en, sel, write_add, fir_add, sec_add, opcode, secin,
    output imem_data, imem_valid, N, Z, C
  );
endinterface

// File: rtl/idp_ctrl_decode.sv
// Pure combinational split of the instruction register into its fields;
// the branch offset is sign-extended or truncated to the PC width.
module idp_ctrl_decode
  import idp_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [15:0]     ir_i,
  output dec_t            dec_o,
  output logic [PC_W-1:0] offset_o
);

  logic unused_ir_bit;

  always_comb begin
    dec_o.cls   = ir_i[CLS_MSB:CLS_LSB];
    dec_o.aluop = ir_i[OP_MSB:OP_LSB];
    dec_o.rd    = ir_i[RD_MSB:RD_LSB];
    dec_o.rs1   = ir_i[RS1_MSB:RS1_LSB];
    dec_o.rs2   = ir_i[RS2_MSB:RS2_LSB];
    dec_o.cond  = ir_i[COND_MSB:COND_LSB];
    offset_o    = PC_W'($signed(ir_i[OFF_MSB:0]));
  end

  assign unused_ir_bit = ir_i[0];

endmodule

// File: rtl/idp_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the idp register file and ALU.
// All outputs come straight from registers; the datapath sees no input-to-output path.
module idp_ctrl #(
  parameter int PC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  idp_ctrl_if.master  bus,
  output logic        busy,
  output logic        halted
);
  import idp_pkg::*;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [15:0]     imm_q;
  logic            nf_q, zf_q, cf_q;
  logic            imem_rd_q, busy_q, halted_q;
  logic            en_q, sel_q;
  logic [2:0]      wa_q, fa_q, sa_q;
  logic [3:0]      op_q;

  dec_t            dec;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] pc_inc_d;
  logic [PC_W-1:0] pc_br_d;
  logic            take_d;

  idp_ctrl_decode #(.PC_W(PC_W)) u_decode (
    .ir_i     (ir_q),
    .dec_o    (dec),
    .offset_o (offset)
  );

  // PC already points past the branch word, so step back one for the branch's own PC.
  always_comb begin
    pc_inc_d = pc_q + PC_W'(1);
    pc_br_d  = pc_q - PC_W'(1) + offset;
    take_d   = cond_met(dec.cond, nf_q, zf_q, cf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      imm_q     <= '0;
      nf_q      <= 1'b0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      imem_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= 1'b0;
      wa_q      <= '0;
      fa_q      <= '0;
      sa_q      <= '0;
      op_q      <= '0;
    end else begin
      en_q  <= 1'b0;
      sel_q <= 1'b0;
      wa_q  <= '0;
      fa_q  <= '0;
      sa_q  <= '0;
      op_q  <= '0;
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_q   <= ST_FETCH;
            imem_rd_q <= 1'b1;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.imem_valid) begin
            ir_q      <= bus.imem_data;
            pc_q      <= pc_inc_d;
            imem_rd_q <= 1'b0;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (dec.cls)
            CLS_ALU_REG: begin
              state_q <= ST_EXEC;
              en_q    <= 1'b1;
              wa_q    <= dec.rd;
              fa_q    <= dec.rs1;
              sa_q    <= dec.rs2;
              op_q    <= dec.aluop;
            end
            CLS_ALU_IMM: begin
              state_q   <= ST_FETCH_IMM;
              imem_rd_q <= 1'b1;
            end
            CLS_BRANCH: state_q <= ST_EXEC;
            default: begin
              state_q  <= ST_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end
          endcase
        end
        ST_FETCH_IMM: begin
          if (bus.imem_valid) begin
            imm_q     <= bus.imem_data;
            pc_q      <= pc_inc_d;
            imem_rd_q <= 1'b0;
            state_q   <= ST_EXEC;
            en_q      <= 1'b1;
            sel_q     <= 1'b1;
            wa_q      <= dec.rd;
            fa_q      <= dec.rs1;
            op_q      <= dec.aluop;
          end
        end
        ST_EXEC: begin
          if (dec.cls == CLS_BRANCH) begin
            if (take_d) pc_q <= pc_br_d;
          end else begin
            {nf_q, zf_q, cf_q} <= {bus.N, bus.Z, bus.C};
          end
          // IMM doubles as the secin driver, so clear it once EXEC is over.
          imm_q     <= '0;
          imem_rd_q <= 1'b1;
          state_q   <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_rd   = imem_rd_q;
  assign bus.en        = en_q;
  assign bus.sel       = sel_q;
  assign bus.write_add = wa_q;
  assign bus.fir_add   = fa_q;
  assign bus.sec_add   = sa_q;
  assign bus.opcode    = op_q;
  assign bus.secin     = imm_q;
  assign busy          = busy_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_idp_ctrl.sv
// Directed bench for idp_ctrl: instruction memory model with programmable wait states
// and hand-encoded programs for each scenario.
module tb_idp_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic halted;

  logic [15:0] mem [256];
  int waits = 0;
  int wcnt = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idp_ctrl_if #(.PC_W(8)) bus ();

  idp_ctrl #(.PC_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus.master),
    .busy   (busy),
    .halted (halted)
  );

  // Memory answers after 'waits' idle cycles of an outstanding request.
  always @(negedge clk) begin
    if (bus.imem_rd === 1'b1) begin
      if (wcnt >= waits) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = mem[bus.imem_addr];
        wcnt = 0;
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'h0000;
        wcnt++;
      end
    end else begin
      bus.imem_valid = 1'b0;
      bus.imem_data  = 16'h0000;
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
  endtask

  task automatic start_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    load_default();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({busy, halted, bus.en, bus.imem_rd} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctrl cycle %0d: busy/halted/en/rd=%b expected 0000", c,
                 {busy, halted, bus.en, bus.imem_rd});
      end
      checks++;
      if (bus.imem_addr !== 8'd0 ||
          {bus.sel, bus.write_add, bus.fir_add, bus.sec_add, bus.opcode, bus.secin} !== 30'd0) begin
        failures++;
        $display("FAIL reset_outs cycle %0d: addr=%h ctl=%h expected all zero", c,
                 bus.imem_addr, {bus.sel, bus.write_add, bus.fir_add, bus.sec_add, bus.opcode, bus.secin});
      end
    end
  endtask

  task automatic test_alu_reg();
    load_default();
    mem[0] = 16'h0994;  // ALU-reg op=2 rd=3 rs1=1 rs2=2
    waits = 0;
    do_reset();
    start_prog();
    checks++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL alu_reg_fetch: rd=%b addr=%h busy=%b expected 1/00/1", bus.imem_rd, bus.imem_addr, busy);
    end
    tick();
    checks++;
    if (bus.en !== 1'b0 || bus.imem_rd !== 1'b0) begin
      failures++;
      $display("FAIL alu_reg_decode: en=%b rd=%b expected 0/0", bus.en, bus.imem_rd);
    end
    tick();
    checks++;
    if ({bus.en, bus.write_add, bus.fir_add, bus.sec_add, bus.opcode, bus.sel} !==
        {1'b1, 3'd3, 3'd1, 3'd2, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL alu_reg_exec: en=%b wa=%0d fa=%0d sa=%0d op=%0d sel=%b expected 1/3/1/2/2/0",
               bus.en, bus.write_add, bus.fir_add, bus.sec_add, bus.opcode, bus.sel);
    end
    tick();
    checks++;
    if (bus.en !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd1) begin
      failures++;
      $display("FAIL alu_reg_next: en=%b rd=%b addr=%h expected 0/1/01", bus.en, bus.imem_rd, bus.imem_addr);
    end
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL alu_reg_halt: halted=%b busy=%b expected 1/0", halted, busy);
    end
  endtask

  task automatic test_alu_imm();
    load_default();
    mem[0] = 16'h5660;  // ALU-imm op=5 rd=4 rs1=6
    mem[1] = 16'h1234;
    waits = 2;
    do_reset();
    start_prog();
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin
        checks++;
        if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd0) begin
          failures++;
          $display("FAIL imm_wait_fetch: rd=%b addr=%h expected 1/00", bus.imem_rd, bus.imem_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd1) begin
          failures++;
          $display("FAIL imm_wait_imm: rd=%b addr=%h expected 1/01", bus.imem_rd, bus.imem_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.en !== 1'b0) begin
          failures++;
          $display("FAIL imm_early_en: en=%b expected 0", bus.en);
        end
      end
      if (c == 8) begin
        checks++;
        if ({bus.en, bus.sel, bus.secin, bus.write_add, bus.fir_add, bus.sec_add, bus.opcode} !==
            {1'b1, 1'b1, 16'h1234, 3'd4, 3'd6, 3'd0, 4'd5}) begin
          failures++;
          $display("FAIL imm_exec: en=%b sel=%b secin=%h wa=%0d fa=%0d sa=%0d op=%0d expected 1/1/1234/4/6/0/5",
                   bus.en, bus.sel, bus.secin, bus.write_add, bus.fir_add, bus.sec_add, bus.opcode);
        end
      end
      if (c == 9) begin
        checks++;
        if ({bus.en, bus.sel, bus.secin} !== 18'd0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd2) begin
          failures++;
          $display("FAIL imm_next: en=%b sel=%b secin=%h rd=%b addr=%h expected 0/0/0000/1/02",
                   bus.en, bus.sel, bus.secin, bus.imem_rd, bus.imem_addr);
        end
      end
      if (c < 9) tick();
    end
  endtask

  task automatic test_branch(input logic zin, input logic [7:0] exp_addr);
    int n;
    load_default();
    for (int i = 0; i < 5; i++) mem[i] = 16'h0994;
    mem[5] = 16'h9FFD;  // branch if Z, offset -3
    waits = 0;
    bus.Z = zin;
    do_reset();
    start_prog();
    n = 0;
    while (!(bus.imem_rd === 1'b1 && bus.imem_addr === 8'd5) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL branch_reach z=%b: no fetch at 05 within %0d cycles, addr=%h", zin, n, bus.imem_addr);
    end
    tick();
    tick();
    checks++;
    if (bus.en !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL branch_exec z=%b: en=%b busy=%b expected 0/1", zin, bus.en, busy);
    end
    tick();
    checks++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== exp_addr) begin
      failures++;
      $display("FAIL branch_target z=%b: rd=%b addr=%h expected 1/%h", zin, bus.imem_rd, bus.imem_addr, exp_addr);
    end
    bus.Z = 1'b0;
  endtask

  task automatic test_halt_wrap();
    load_default();
    mem[0] = 16'h8FFF;  // branch always, offset -1 -> 255
    waits = 0;
    do_reset();
    start_prog();
    tick();
    tick();
    tick();
    checks++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'hFF) begin
      failures++;
      $display("FAIL wrap_fetch: rd=%b addr=%h expected 1/ff", bus.imem_rd, bus.imem_addr);
    end
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || bus.imem_addr !== 8'd0 || bus.imem_rd !== 1'b0) begin
      failures++;
      $display("FAIL wrap_halt: halted=%b busy=%b addr=%h rd=%b expected 1/0/00/0",
               halted, busy, bus.imem_addr, bus.imem_rd);
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL wrap_hold: halted=%b expected 1", halted);
    end
    start_prog();
    checks++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd0 || halted !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wrap_restart: rd=%b addr=%h halted=%b busy=%b expected 1/00/0/1",
               bus.imem_rd, bus.imem_addr, halted, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    load_default();
    mem[0] = 16'h0994;  // sets zf from Z=1
    mem[1] = 16'h5660;
    mem[2] = 16'h1234;
    waits = 2;
    bus.Z = 1'b1;
    do_reset();
    start_prog();
    n = 0;
    while (!(bus.imem_rd === 1'b1 && bus.imem_addr === 8'd2) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL mid_reach: no immediate fetch within %0d cycles, addr=%h", n, bus.imem_addr);
    end
    tick();
    tick();
    rst = 1'b0;  // the immediate is being returned this cycle
    tick();
    checks++;
    if ({busy, halted, bus.en, bus.imem_rd} !== 4'b0000 || bus.imem_addr !== 8'd0) begin
      failures++;
      $display("FAIL mid_abort: busy/halted/en/rd=%b addr=%h expected 0000/00",
               {busy, halted, bus.en, bus.imem_rd}, bus.imem_addr);
    end
    mem[0] = 16'h9004;  // branch if Z, offset +4
    bus.Z = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_idle cycle %0d: en=%b busy=%b expected 0/0", c, bus.en, busy);
      end
    end
    start_prog();
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'd1) begin
      failures++;
      $display("FAIL mid_flags_cleared: rd=%b addr=%h expected 1/01", bus.imem_rd, bus.imem_addr);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.N = 1'b0;
    bus.Z = 1'b0;
    bus.C = 1'b0;
    test_reset();
    test_alu_reg();
    test_alu_imm();
    test_branch(1'b1, 8'd2);
    test_branch(1'b0, 8'd6);
    test_halt_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idp_ctrl.md
# idp_ctrl

Multi-cycle sequencer for the `idp` register-file/ALU datapath. It fetches 16-bit instruction words from an instruction memory over a valid handshake and decodes them. It drives the datapath control inputs: `en`, `sel`, `write_add`, `fir_add`, `sec_add`, `opcode` and `secin`. It latches the `N`/`Z`/`C` flags and uses them to resolve conditional branches. It sits between instruction memory and `idp`, and is the only block that writes the register file.

## Interface
- `PC_W`, default 8: program counter and instruction address width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begins execution from the current PC when the block is in IDLE or HALT.
- `imem_addr`  out  PC_W  instruction fetch address.
- `imem_rd`  out  1  fetch request.
- `imem_data`  in  16  instruction or immediate word.
- `imem_valid`  in  1  `imem_data` is valid this cycle.
- `N`, `Z`, `C`  in  1 each  ALU flags from `idp`.
- `en`  out  1  register-file write enable to `idp`.
- `sel`  out  1  ALU second-operand select: 1 = `secin`, 0 = register.
- `write_add`, `fir_add`, `sec_add`  out  3 each  register addresses to `idp`.
- `opcode`  out  4  ALU operation code, passed through unmodified.
- `secin`  out  16  immediate operand.
- `busy`  out  1  high in any state other than IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
Instruction word fields:
- `[15:14]` class.
- `[13:10]` ALU op.
- `[9:7]` rd.
- `[6:4]` rs1.
- `[3:1]` rs2.

Instruction classes:
- **00, ALU-reg:** `rd <= rs1 op rs2`.
- **01, ALU-imm:** the next word is a 16-bit immediate; `rd <= rs1 op imm`.
- **10, branch:** `[13:12]` is the condition: 00 always, 01 Z, 10 N, 11 C. `[PC_W-1:0]` of `[11:0]` is a signed two's-complement offset relative to the branch's own PC.
- **11, HALT.**

State machine:
- IDLE → FETCH on `start`.
- FETCH:
  - `imem_rd`=1 and `imem_addr`=PC.
  - Holds until `imem_valid`=1.
  - On that edge: IR <= `imem_data`, PC <= PC+1, go to DECODE.
- DECODE:
  - Class 00 → EXEC.
  - Class 01 → FETCH_IMM.
  - Class 10 → EXEC.
  - Class 11 → HALT.
- FETCH_IMM: same handshake as FETCH. On `imem_valid`: IMM <= `imem_data`, PC <= PC+1, go to EXEC.
- EXEC, ALU classes:
  - `en`=1 for exactly one cycle.
  - `write_add`=rd, `fir_add`=rs1, `sec_add`=rs2 (0 for class 01).
  - `opcode`=ALU op.
  - `sel`=1 and `secin`=IMM for class 01; otherwise `sel`=0.
  - Flag register {nf,zf,cf} <= {N,Z,C} on the same edge.
  - Then go to FETCH.
- EXEC, branch:
  - `en`=0.
  - If the condition holds on the latched flags, PC <= branch_pc + offset; else PC is unchanged (already branch_pc+1).
  - Flags are not updated.
  - Then go to FETCH.
- HALT: outputs idle. `start` → FETCH, continuing from the PC after the HALT word.

Outside EXEC, `en`, `sel`, the three addresses, `opcode` and `secin` are all 0. Outputs depend only on registered state, with no combinational path from any input to any output.

Arithmetic and boundary rules:
- PC arithmetic is modulo 2^PC_W.
- Branch offset is sign-extended/truncated to PC_W.
- Increment past all ones wraps to 0.
- `start` while busy is ignored.
- `imem_valid` outside FETCH/FETCH_IMM is ignored.
- An ALU op writing to rd=rs1 is legal; `idp` reads before the edge.

## Timing
- Reset: state=IDLE, PC=0, IR=0, IMM=0, flags=0, and all outputs 0.
- Reset asserted in any state, including mid-fetch, aborts to the reset state on the next edge. The pending memory response is discarded.
- Latency with zero-wait memory (`imem_valid` in the same cycle as `imem_rd`):
  - ALU-reg: 3 cycles (FETCH, DECODE, EXEC).
  - ALU-imm: 4 cycles.
  - Branch: 3 cycles.
  - HALT: 2 cycles to `halted`=1.
- Each memory wait cycle adds one cycle. `imem_addr` is held stable while waiting.
- The register write and the flag capture occur on the rising edge that ends EXEC.

## Structure
- `idp_pkg` holds:
  - state enum (IDLE, FETCH, DECODE, FETCH_IMM, EXEC, HALT);
  - class constants;
  - branch condition constants;
  - instruction field bit-position localparams.
- One combinational sub-module, `idp_ctrl_decode`: IR → {class, aluop, rd, rs1, rs2, cond, offset}.
- The top level holds the FSM, PC, IR, IMM and flag registers.

## Test plan
- **Reset/idle:** hold `rst`=0 for 2 cycles, release, no `start` → `busy`=0, `en`=0, `imem_rd`=0, `imem_addr`=0 indefinitely.
- **ALU-reg:** mem[0]=0x0_?? encoding op=0x2, rd=3, rs1=1, rs2=2; zero-wait → `en`=1 in cycle 3 with `write_add`=3, `fir_add`=1, `sec_add`=2, `opcode`=2, `sel`=0; next fetch at address 1.
- **ALU-imm with 2 wait cycles per fetch:** immediate word 0x1234 → EXEC in cycle 8, `sel`=1, `secin`=0x1234; next fetch at address 2.
- **Conditional branch:**
  - An ALU op returns Z=1, followed by a branch at PC=5 with cond=Z and offset=−3 → next fetch at address 2.
  - Same sequence with Z=0 → next fetch at address 6.
- **HALT and wrap:**
  - HALT at address 255 (PC_W=8) → `halted`=1, PC=0.
  - `start` → fetch at address 0.
- **Reset mid-operation:** assert `rst`=0 during FETCH_IMM while `imem_valid` is pending → next cycle IDLE, PC=0, flags=0, no `en` pulse.
